// File: rtl/dmem_port.sv
// dmem_port: requester-side port between the core's memory stage and a single-port word SRAM.
// Define DMEM_SPLIT_EN to split word-crossing accesses into a lo/hi access pair; otherwise they error.
module dmem_port #(
  parameter int AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [AWIDTH+1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              CSN,
  output logic [AWIDTH-1:0] ADDR,
  output logic              WEN,
  output logic [3:0]        BE,
  output logic [31:0]       DI,
  input  logic [31:0]       DOUT
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    RD_LO  = 3'd2,
    ACC_HI = 3'd3,
    RD_HI  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              csn_q, csn_d;
  logic              wen_q, wen_d;
  logic [3:0]        be_q, be_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       di_q, di_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic              split_q, split_d;
  logic [3:0]        hi_be_q, hi_be_d;
  logic [31:0]       hi_di_q, hi_di_d;
  logic [31:0]       lo_q, lo_d;

  logic [3:0]        mask;
  logic [7:0]        lane8;
  logic [63:0]       wd_sh;
  logic              legal;
  logic              split_req;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'h1;
      2'b01:   return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  // Pull the addressed bytes out of the {hi,lo} word pair and extend them to 32 bits.
  function automatic logic [31:0] extend_load(input logic [63:0] pair, input logic [1:0] off,
                                              input logic [1:0] sz, input logic uns);
    logic [31:0]        sh;
    logic signed [31:0] sx;
    logic [31:0]        zx;
    sh = 32'(pair >> {off, 3'b000});
    case (sz)
      2'b00: begin
        sx = 32'($signed(sh[7:0]));
        zx = {24'h0, sh[7:0]};
      end
      2'b01: begin
        sx = 32'($signed(sh[15:0]));
        zx = {16'h0, sh[15:0]};
      end
      default: begin
        sx = $signed(sh);
        zx = sh;
      end
    endcase
    return uns ? zx : sx;
  endfunction

  always_comb begin
    mask  = size_mask(REQ_SIZE);
    lane8 = {4'h0, mask} << REQ_ADDR[1:0];
    wd_sh = {32'h0, REQ_WDATA} << {REQ_ADDR[1:0], 3'b000};
`ifdef DMEM_SPLIT_EN
    legal     = (REQ_SIZE != 2'b11);
    split_req = |lane8[7:4];
`else
    legal     = (REQ_SIZE == 2'b00) ||
                ((REQ_SIZE == 2'b01) && !REQ_ADDR[0]) ||
                ((REQ_SIZE == 2'b10) && (REQ_ADDR[1:0] == 2'b00));
    split_req = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    csn_d       = 1'b1;
    wen_d       = wen_q;
    be_d        = be_q;
    addr_d      = addr_q;
    di_d        = di_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    split_d     = split_q;
    hi_be_d     = hi_be_q;
    hi_di_d     = hi_di_q;
    lo_d        = lo_q;

    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          we_d    = REQ_WE;
          size_d  = REQ_SIZE;
          uns_d   = REQ_UNSIGNED;
          off_d   = REQ_ADDR[1:0];
          split_d = split_req;
          hi_be_d = lane8[7:4];
          hi_di_d = wd_sh[63:32];
          if (legal) begin
            csn_d   = 1'b0;
            addr_d  = REQ_ADDR[AWIDTH+1:2];
            wen_d   = ~REQ_WE;
            be_d    = lane8[3:0];
            di_d    = wd_sh[31:0];
            state_d = ACC_LO;
          end else begin
            state_d = RESP;
          end
        end
      end

      ACC_LO: begin
        if (we_q) begin
          if (split_q) begin
            csn_d   = 1'b0;
            addr_d  = addr_q + AWIDTH'(1);
            be_d    = hi_be_q;
            di_d    = hi_di_q;
            state_d = ACC_HI;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
            state_d     = RESP;
          end
        end else begin
          state_d = RD_LO;
        end
      end

      RD_LO: begin
        lo_d = DOUT;
        if (split_q) begin
          csn_d   = 1'b0;
          addr_d  = addr_q + AWIDTH'(1);
          be_d    = hi_be_q;
          state_d = ACC_HI;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = extend_load({32'h0, DOUT}, off_q, size_q, uns_q);
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end
      end

      ACC_HI: begin
        if (we_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          state_d = RD_HI;
        end
      end

      RD_HI: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = extend_load({DOUT, lo_q}, off_q, size_q, uns_q);
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end

      RESP: begin
        // Arriving here with no pulse pending means the request was rejected at accept.
        if (rsp_valid_q) begin
          state_d = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      csn_q       <= 1'b1;
      wen_q       <= 1'b1;
      be_q        <= 4'h0;
      addr_q      <= '0;
      di_q        <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      csn_q       <= csn_d;
      wen_q       <= wen_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Request attributes and the lo read word are only consumed after being written.
  always_ff @(posedge CLK) begin
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    off_q   <= off_d;
    split_q <= split_d;
    hi_be_q <= hi_be_d;
    hi_di_q <= hi_di_d;
    lo_q    <= lo_d;
  end

  assign REQ_READY = (state_q == IDLE) & ~RST;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign CSN       = csn_q;
  assign ADDR      = addr_q;
  assign WEN       = wen_q;
  assign BE        = be_q;
  assign DI        = di_q;

endmodule
